alu_mul_seq: RTL and testbench

- Iterative unsigned multiplier controller that sequences the shared 32-bit main ALU through shift-add steps, using ALUSel 4'h2 (add).
- Sits beside the multicycle control unit. When the control unit raises start, this block takes the ALU operand and select lines, runs one add per cycle, and returns the low word_size bits of the product with a one-cycle done pulse.
- The ALU stays purely combinational. This block owns all sequencing state.

---
 rtl/alu_mul_seq_if.sv | 26 ++
 rtl/alu_mul_seq.sv | 84 ++++++++
 tb/tb_alu_mul_seq.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/alu_mul_seq_if.sv
// Handshake and ALU-sharing bundle between the multicycle control unit / main ALU
// (master) and the shift-add multiplier sequencer (slave).
interface alu_mul_seq_if #(
    parameter int word_size = 32
);
    logic                 start;
    logic [word_size-1:0] op_a;
    logic [word_size-1:0] op_b;
    logic                 busy;
    logic                 done;
    logic [word_size-1:0] product;
    logic [word_size-1:0] alu_srcA;
    logic [word_size-1:0] alu_srcB;
    logic [3:0]           alu_sel;
    logic [word_size-1:0] alu_result;

    modport master (
        output start, op_a, op_b, alu_result,
        input  busy, done, product, alu_srcA, alu_srcB, alu_sel
    );

    modport slave (
        input  start, op_a, op_b, alu_result,
        output busy, done, product, alu_srcA, alu_srcB, alu_sel
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier that borrows the shared main ALU for its adds.
// Optional macro ALU_MUL_SEQ_EARLY_EXIT_EN stops iterating once no multiplier bits remain.
module alu_mul_seq #(
    parameter int word_size = 32,
    parameter int cnt_w     = 6
) (
    input  logic         clk,
    input  logic         rst,
    alu_mul_seq_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for start; ALU select parked at 4'h0
    // RUN   | one shift-add iteration per edge through the shared ALU
    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [cnt_w-1:0] LAST_CNT = cnt_w'(word_size - 1);

    state_t               r_state;
    logic                 r_busy;
    logic                 r_done;
    logic [word_size-1:0] r_product;
    logic [word_size-1:0] r_acc;
    logic [word_size-1:0] r_m;
    logic [word_size-1:0] r_q;
    logic [cnt_w-1:0]     r_count;

    logic [word_size-1:0] w_acc_next;
    logic                 w_last;

    assign w_acc_next = r_q[0] ? bus.alu_result : r_acc;

`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
    assign w_last = (r_count == LAST_CNT) || ((r_q >> 1) == '0);
`else
    assign w_last = (r_count == LAST_CNT);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
            r_acc     <= '0;
            r_m       <= '0;
            r_q       <= '0;
            r_count   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_m     <= bus.op_a;
                        r_q     <= bus.op_b;
                        r_acc   <= '0;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_acc_next;
                    r_m     <= r_m << 1;
                    r_q     <= r_q >> 1;
                    r_count <= r_count + 1'b1;
                    if (w_last) begin
                        r_product <= w_acc_next;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.product  = r_product;
    assign bus.alu_srcA = r_acc;
    assign bus.alu_srcB = (r_state == S_RUN) ? r_m : '0;
    assign bus.alu_sel  = (r_state == S_RUN) ? 4'h2 : 4'h0;
endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed-vector bench for alu_mul_seq with a behavioural main ALU (4'h2 = add).
module tb_alu_mul_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    always #5 clk = ~clk;

    alu_mul_seq_if #(.word_size(32)) bus ();

    alu_mul_seq #(.word_size(32), .cnt_w(6)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    assign bus.alu_result = (bus.alu_sel == 4'h2) ? bus.alu_srcA + bus.alu_srcB
                                                  : bus.alu_srcA & bus.alu_srcB;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Issue start with a,b; E0 is the edge that samples it.
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op_a = a; bus.op_b = b;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op_a = 32'hDEAD_BEEF; bus.op_b = 32'h1234_5678;
    endtask

    // Counts edges after E0 until done; checks busy/sel during RUN.
    task automatic wait_done(input string tag, input int exp_iter, input logic [31:0] exp_prod);
        int  k;
        bit  bad;
        k = 0; bad = 1'b0;
        while (!bus.done && k < 40) begin
            if (bus.busy !== 1'b1 || bus.alu_sel !== 4'h2) bad = 1'b1;
            @(posedge clk); #1;
            k++;
        end
        chk({tag, "_iters"}, k, exp_iter);
        chk({tag, "_prod"}, bus.product, exp_prod);
        chk({tag, "_run_ctl"}, {31'd0, bad}, 32'd0);
        chk({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input int early_iter, input logic [31:0] exp_prod);
        launch(a, b);
        wait_done(tag, EE ? early_iter : 32, exp_prod);
        @(posedge clk); #1;
        chk({tag, "_done_1cyc"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        int  k;
        bit  seen;
        bit  held_bad;
        bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_prod", bus.product, 32'd0);
        chk("rst_sel", {28'd0, bus.alu_sel}, 32'd0);
        chk("rst_srcA", bus.alu_srcA, 32'd0);
        chk("rst_srcB", bus.alu_srcB, 32'd0);
        rst = 1'b0;

        do_op("m7x6", 32'd7, 32'd6, 3, 32'd42);
        do_op("mffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 32'h0000_0001);
        do_op("wrap", 32'h0001_0000, 32'h0001_0000, 17, 32'h0000_0000);

        // 3*5 with an ignored start mid-run, then back-to-back 9*9 from the done cycle
        launch(32'd3, 32'd5);
        k = 0;
        while (!bus.done && k < 40) begin
            if (k == (EE ? 1 : 10)) begin
                bus.start = 1'b1; bus.op_a = 32'd9; bus.op_b = 32'd9;
            end else begin
                bus.start = 1'b0; bus.op_a = 32'd0; bus.op_b = 32'd0;
            end
            @(posedge clk); #1;
            k++;
        end
        chk("ign_iters", k, EE ? 3 : 32);
        chk("ign_prod", bus.product, 32'd15);
        bus.start = 1'b1; bus.op_a = 32'd9; bus.op_b = 32'd9;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op_a = 32'd0; bus.op_b = 32'd0;
        chk("b2b_busy", {31'd0, bus.busy}, 32'd1);
        chk("b2b_done_clr", {31'd0, bus.done}, 32'd0);
        held_bad = 1'b0;
        k = 0;
        while (!bus.done && k < 40) begin
            if (bus.product !== 32'd15) held_bad = 1'b1;
            @(posedge clk); #1;
            k++;
        end
        chk("b2b_held15", {31'd0, held_bad}, 32'd0);
        chk("b2b_iters", k, EE ? 4 : 32);
        chk("b2b_prod", bus.product, 32'd81);

        // Abort 123*456 with reset partway through the run
        launch(32'd123, 32'd456);
        repeat ((EE ? 5 : 20) - 1) @(posedge clk);
        #1;
        chk("abort_pre_busy", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_prod", bus.product, 32'd0);
        chk("abort_sel", {28'd0, bus.alu_sel}, 32'd0);
        #3 rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) seen = 1'b1;
        end
        chk("abort_no_done", {31'd0, seen}, 32'd0);
        chk("abort_prod_after", bus.product, 32'd0);

        do_op("m2x3", 32'd2, 32'd3, 2, 32'd6);
        do_op("bzero", 32'd5, 32'd0, 1, 32'd0);
        do_op("m10x3", 32'd10, 32'd3, 2, 32'd30);
        do_op("msb", 32'd1, 32'h8000_0000, 32, 32'h8000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
